// File: rtl/botonera_antirrebote.sv
// Front-panel button conditioning: 2-flop sync, per-button debounce, one-hot held event with Ack/timeout.
// Optional autorepeat for arriba/abajo is built when the AUTOREPEAT_EN macro is defined.
module botonera_antirrebote #(
    parameter logic [15:0] DEB_CYC  = 16'd50000,
    parameter logic [23:0] HOLD_MAX = 24'd1000000
`ifdef AUTOREPEAT_EN
    ,
    parameter logic [23:0] REP_DELAY = 24'd25000000,
    parameter logic [23:0] REP_RATE  = 24'd5000000
`endif
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] BTN,
    input  logic       Ack,
    output logic       Barriba,
    output logic       Babajo,
    output logic       Bderecha,
    output logic       Bizquierda,
    output logic       Bcentro,
    output logic       Pend
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    logic [4:0]  sync1_r;
    logic [4:0]  sync2_r;
    logic [4:0]  stable_r;
    logic [4:0]  stable_d_r;
    logic [4:0]  armed_r;
    logic [4:0]  press_r;
    logic [1:0]  valid_r;
    logic [15:0] deb_cnt_r [5];

    logic [4:0]  rise_s;
    logic [4:0]  rep_hit_s;
    logic [4:0]  strobe_s;

    state_t      state_r;
    state_t      state_s;
    logic [4:0]  evt_r;
    logic [4:0]  evt_s;
    logic        pend_r;
    logic        pend_s;
    logic [23:0] hold_cnt_r;
    logic [23:0] hold_cnt_s;

    // Fixed arbitration order: centro > izquierda > derecha > arriba > abajo
    function automatic logic [4:0] pick_one(input logic [4:0] req);
        logic [4:0] grant;
        if (req[4]) begin
            grant = 5'b10000;
        end else if (req[3]) begin
            grant = 5'b01000;
        end else if (req[2]) begin
            grant = 5'b00100;
        end else if (req[0]) begin
            grant = 5'b00001;
        end else if (req[1]) begin
            grant = 5'b00010;
        end else begin
            grant = 5'b00000;
        end
        return grant;
    endfunction

    // Two-flop synchroniser plus a marker telling when sync2 holds a real sample
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_r <= 5'b0;
            sync2_r <= 5'b0;
            valid_r <= 2'b0;
        end else begin
            sync1_r <= BTN;
            sync2_r <= sync1_r;
            valid_r <= {valid_r[0], 1'b1};
        end
    end

    // Per-button debounce: stable level flips after DEB_CYC consecutive differing samples
    always_ff @(posedge CLK) begin
        if (RST) begin
            stable_r <= 5'b0;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_r[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    deb_cnt_r[i] <= 16'd0;
                end else if (deb_cnt_r[i] == (DEB_CYC - 16'd1)) begin
                    stable_r[i]  <= ~stable_r[i];
                    deb_cnt_r[i] <= 16'd0;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + 16'd1;
                end
            end
        end
    end

    // A button only produces presses once it has been seen released since reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            stable_d_r <= 5'b0;
            armed_r    <= 5'b0;
            press_r    <= 5'b0;
        end else begin
            stable_d_r <= stable_r;
            armed_r    <= armed_r | ({5{valid_r[1]}} & ~sync2_r & ~stable_r);
            press_r    <= strobe_s;
        end
    end

`ifdef AUTOREPEAT_EN
    logic [23:0] rep_cnt_r   [2];
    logic [1:0]  rep_phase_r;

    // Repeat strobe fires at REP_DELAY after the rise, then every REP_RATE
    always_comb begin
        rep_hit_s = 5'b0;
        for (int i = 0; i < 2; i++) begin
            if (stable_r[i] && (rep_cnt_r[i] == (rep_phase_r[i] ? REP_RATE : REP_DELAY))) begin
                rep_hit_s[i] = 1'b1;
            end else begin
                rep_hit_s[i] = 1'b0;
            end
        end
    end

    // Repeat counters run while the stable level is high and clear on release
    always_ff @(posedge CLK) begin
        if (RST) begin
            rep_phase_r <= 2'b0;
            for (int i = 0; i < 2; i++) begin
                rep_cnt_r[i] <= 24'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!stable_r[i]) begin
                    rep_cnt_r[i]   <= 24'd0;
                    rep_phase_r[i] <= 1'b0;
                end else if (rep_hit_s[i]) begin
                    rep_cnt_r[i]   <= 24'd1;
                    rep_phase_r[i] <= 1'b1;
                end else begin
                    rep_cnt_r[i]   <= rep_cnt_r[i] + 24'd1;
                end
            end
        end
    end
`else
    // No autorepeat in this build
    always_comb begin
        rep_hit_s = 5'b0;
    end
`endif

    // Press strobes: stable rising edges plus any repeat hits, gated by arming
    always_comb begin
        rise_s   = stable_r & ~stable_d_r;
        strobe_s = (rise_s | rep_hit_s) & armed_r;
    end

    // Event FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            evt_r      <= 5'b0;
            pend_r     <= 1'b0;
            hold_cnt_r <= 24'd0;
        end else begin
            state_r    <= state_s;
            evt_r      <= evt_s;
            pend_r     <= pend_s;
            hold_cnt_r <= hold_cnt_s;
        end
    end

    // Event FSM next state: latch one press in IDLE, hold until Ack or timeout
    always_comb begin
        state_s    = state_r;
        evt_s      = evt_r;
        pend_s     = pend_r;
        hold_cnt_s = hold_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (|press_r) begin
                    evt_s      = pick_one(press_r);
                    pend_s     = 1'b1;
                    hold_cnt_s = 24'd0;
                    state_s    = ST_HOLD;
                end else begin
                    evt_s      = 5'b0;
                    pend_s     = 1'b0;
                    hold_cnt_s = 24'd0;
                end
            end
            ST_HOLD: begin
                if (Ack || (hold_cnt_r == (HOLD_MAX - 24'd1))) begin
                    evt_s      = 5'b0;
                    pend_s     = 1'b0;
                    hold_cnt_s = 24'd0;
                    state_s    = ST_IDLE;
                end else begin
                    hold_cnt_s = hold_cnt_r + 24'd1;
                end
            end
            default: begin
                evt_s      = 5'b0;
                pend_s     = 1'b0;
                hold_cnt_s = 24'd0;
                state_s    = ST_IDLE;
            end
        endcase
    end

    assign Barriba    = evt_r[0];
    assign Babajo     = evt_r[1];
    assign Bderecha   = evt_r[2];
    assign Bizquierda = evt_r[3];
    assign Bcentro    = evt_r[4];
    assign Pend       = pend_r;

endmodule

// File: tb/tb_botonera_antirrebote.sv
// Randomised bench for botonera_antirrebote against a sample-window reference model.
// Define AUTOREPEAT_EN to also exercise the autorepeat build.
module tb_botonera_antirrebote;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int RD   = 40;
    localparam int RR   = 30;
    localparam int HN   = 8192;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] BTN;
    logic       Ack;
    logic       Barriba, Babajo, Bderecha, Bizquierda, Bcentro, Pend;
    logic [4:0] obs_evt;

    assign obs_evt = {Bcentro, Bizquierda, Bderecha, Babajo, Barriba};

    botonera_antirrebote #(
        .DEB_CYC(16'd4),
        .HOLD_MAX(24'd20)
`ifdef AUTOREPEAT_EN
        ,
        .REP_DELAY(24'd40),
        .REP_RATE(24'd30)
`endif
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .BTN(BTN),
        .Ack(Ack),
        .Barriba(Barriba),
        .Babajo(Babajo),
        .Bderecha(Bderecha),
        .Bizquierda(Bizquierda),
        .Bcentro(Bcentro),
        .Pend(Pend)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // Reference model: raw sample history and event bookkeeping
    logic [4:0] raw_hist [HN];
    logic [4:0] m_stable, m_armed, m_strobe, m_press, m_evt;
    logic       m_pend, m_hold;
    int         m_start, m_valid_from;
    int         m_rise [2];
    int         prio [5] = '{4, 3, 2, 0, 1};

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_step();
        int k;
        int j;
        logic [4:0] st_old;
        logic all_diff;
        k = edge_n;
        if (RST) begin
            raw_hist[k % HN]          = 5'b0;
            raw_hist[(k - 1 + HN) % HN] = 5'b0;
            m_stable = 5'b0; m_armed = 5'b0; m_strobe = 5'b0; m_press = 5'b0;
            m_evt = 5'b0; m_pend = 1'b0; m_hold = 1'b0;
            m_valid_from = k + 3;
            m_rise[0] = 0; m_rise[1] = 0;
        end else begin
            raw_hist[k % HN] = BTN;
            if (m_hold) begin
                if (Ack || ((k - m_start) == HOLD)) begin
                    m_hold = 1'b0; m_evt = 5'b0; m_pend = 1'b0;
                end
            end else if (m_press != 5'b0) begin
                m_evt = 5'b0;
                for (int p = 0; p < 5; p++) begin
                    if (m_evt == 5'b0 && m_press[prio[p]]) m_evt[prio[p]] = 1'b1;
                end
                m_hold = 1'b1; m_pend = 1'b1; m_start = k;
            end
            m_press = m_strobe;
            st_old = m_stable;
            for (int b = 0; b < 5; b++) begin
                // Flip when the last DEB synchronised samples all disagree with the stable level
                if (k >= DEB + 2) begin
                    all_diff = 1'b1;
                    for (int w = 2; w <= DEB + 1; w++) begin
                        if (raw_hist[(k - w) % HN][b] == st_old[b]) all_diff = 1'b0;
                    end
                    if (all_diff) m_stable[b] = ~st_old[b];
                end
                if (k >= m_valid_from && !raw_hist[(k - 2) % HN][b] && !st_old[b]) m_armed[b] = 1'b1;
            end
            m_strobe = m_stable & ~st_old;
            for (int b = 0; b < 2; b++) begin
                if (m_strobe[b]) m_rise[b] = k;
            end
`ifdef AUTOREPEAT_EN
            for (int b = 0; b < 2; b++) begin
                j = k - m_rise[b];
                if (m_stable[b] && j >= RD && ((j - RD) % RR) == 0) m_strobe[b] = 1'b1;
            end
`endif
            m_strobe = m_strobe & m_armed;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        edge_n++;
        model_step();
        #1;
        check_val("outs", int'({Pend, obs_evt}), int'({m_pend, m_evt}));
        check_val("onehot", int'($countones(obs_evt) <= 1), 1);
    endtask

    task automatic wait_high(input int bi, input int max, output int e);
        e = -1;
        for (int n = 0; n < max && e < 0; n++) begin
            tick();
            if (obs_evt[bi]) e = edge_n;
        end
        check_val("wait_event", int'(e >= 0), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pe, e, first, cnt, cnt2, prev;
        int dwell [5];
        int asrt [$];
        int exp_rep [5] = '{8, 48, 78, 108, 138};

        for (int i = 0; i < HN; i++) raw_hist[i] = 5'b0;
        RST = 1'b1; BTN = 5'b0; Ack = 1'b0;
        idle(3);
        check_val("reset_outs", int'({Pend, obs_evt}), 0);
        RST = 1'b0;
        idle(6 + $urandom_range(0, 4));

        // Single press held, never acknowledged: timeout after HOLD cycles
        BTN = 5'b00001; pe = edge_n; first = -1; cnt = 0;
        repeat (50) begin
            tick();
            if (obs_evt[0]) begin
                if (first < 0) first = edge_n;
                cnt++;
            end
            if (edge_n - pe == 30) BTN = 5'b0;
        end
        check_val("s1_latency", first - pe, 8);
        check_val("s1_hold_len", cnt, HOLD);

        // Short glitches never qualify
        cnt2 = 0;
        repeat (10) begin
            BTN = 5'b00010;
            repeat ($urandom_range(1, 3)) begin tick(); if (obs_evt != 5'b0) cnt2++; end
            BTN = 5'b0;
            repeat (3) begin tick(); if (obs_evt != 5'b0) cnt2++; end
        end
        check_val("s2_glitch_events", cnt2, 0);
        idle($urandom_range(5, 9));

        // Simultaneous centro and derecha: centro wins, derecha dropped
        BTN = 5'b10100; pe = edge_n; first = -1; cnt = 0;
        repeat (50) begin
            tick();
            if (obs_evt[4] && first < 0) first = edge_n;
            if (obs_evt[2]) cnt++;
            if (edge_n - pe == 30) BTN = 5'b0;
        end
        check_val("s3_centro_latency", first - pe, 8);
        check_val("s3_derecha_count", cnt, 0);

        // Izquierda acknowledged; arriba maturing in HOLD is dropped
        BTN = 5'b01000; pe = edge_n;
        idle(3);
        BTN = 5'b01001;
        wait_high(3, 20, e);
        check_val("s4_izq_latency", e - pe, 8);
        idle(4);
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        check_val("s4_izq_after_ack", int'(Bizquierda), 0);
        check_val("s4_pend_after_ack", int'(Pend), 0);
        cnt = 0;
        repeat (20) begin tick(); if (obs_evt != 5'b0) cnt++; end
        check_val("s4_dropped_press", cnt, 0);
        BTN = 5'b0;
        idle(15);
        BTN = 5'b00001; pe = edge_n;
        wait_high(0, 20, e);
        check_val("s4_fresh_latency", e - pe, 8);
        idle(2);
        Ack = 1'b1; tick(); Ack = 1'b0;
        BTN = 5'b0;
        idle(12);

        // Reset during HOLD; still-held button must be released before it counts
        BTN = 5'b00100; pe = edge_n;
        wait_high(2, 20, e);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_val("s5_outs_after_rst", int'({Pend, obs_evt}), 0);
        cnt = 0;
        repeat (30) begin tick(); if (obs_evt != 5'b0) cnt++; end
        check_val("s5_held_after_rst", cnt, 0);
        BTN = 5'b0;
        idle(15);
        BTN = 5'b00100; pe = edge_n;
        wait_high(2, 20, e);
        check_val("s5_repress_latency", e - pe, 8);
        Ack = 1'b1; tick(); Ack = 1'b0;
        BTN = 5'b0;
        idle(12);

`ifdef AUTOREPEAT_EN
        // Autorepeat on arriba, each event acknowledged one cycle after it appears
        BTN = 5'b00001; pe = edge_n; prev = 0;
        repeat (150) begin
            tick();
            if (obs_evt[0] && !prev) asrt.push_back(edge_n - pe);
            prev = int'(obs_evt[0]);
            Ack = obs_evt[0];
        end
        BTN = 5'b0; Ack = 1'b0;
        idle(20);
        check_val("ar_count", asrt.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check_val("ar_edge", (i < asrt.size()) ? asrt[i] : -1, exp_rep[i]);
        end
`endif

        // Random soak against the model
        for (int b = 0; b < 5; b++) dwell[b] = $urandom_range(1, 14);
        repeat (1500) begin
            for (int b = 0; b < 5; b++) begin
                if (dwell[b] == 0) begin
                    BTN[b] = ~BTN[b];
                    dwell[b] = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 120) : $urandom_range(1, 14);
                end else begin
                    dwell[b]--;
                end
            end
            Ack = ($urandom_range(0, 5) == 0);
            RST = ($urandom_range(0, 299) == 0);
            tick();
        end
        RST = 1'b0; Ack = 1'b0; BTN = 5'b0;
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
